// File: rtl/cok_cevrimli_islemci.sv
// cok_cevrimli_islemci: multicycle RV32I/RV32E-subset core with one valid/ready memory port.
// Define ISLEMCI_SAYAC_EN to add cycle/instret counters readable with CSRRS.
`ifndef VERI_BIT
`define VERI_BIT 32
`endif

module cok_cevrimli_islemci #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h8000_0000,
  parameter int          YAZMAC_SAYISI   = 32,
  parameter int          VERI_BIT        = `VERI_BIT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                bellek_istek,
  input  logic                bellek_hazir,
  output logic [31:0]         bellek_adres,
  output logic                bellek_yaz,
  output logic [VERI_BIT-1:0] bellek_yaz_veri,
  input  logic [VERI_BIT-1:0] bellek_oku_veri,
  output logic                hata
);
  localparam int IW = $clog2(YAZMAC_SAYISI);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
`ifdef ISLEMCI_SAYAC_EN
  localparam logic [6:0] OP_SYS   = 7'b1110011;
`endif

  typedef enum logic [2:0] {SIFIR, GETIR, COZ, YURUT, BELLEK, HATA} durum_t;

  durum_t      state_q, state_d;
  logic [31:0] ps_q, ps_d, buyruk_q, buyruk_d, a_q, a_d, b_q, b_d;
  logic [31:0] imm_q, imm_d, addr_q, addr_d;
  logic        hata_q, hata_d, istek_q, istek_d, yaz_q, yaz_d;
  logic [31:0] adres_q, adres_d, yaz_veri_q, yaz_veri_d;
  logic [31:0] rf_q [YAZMAC_SAYISI];
  logic        rf_we;
  logic [31:0] rf_wd;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = buyruk_q[6:0];
  assign rd     = buyruk_q[11:7];
  assign f3     = buyruk_q[14:12];
  assign rs1    = buyruk_q[19:15];
  assign rs2    = buyruk_q[24:20];
  assign f7     = buyruk_q[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_lw, is_sw, is_addi, is_r, is_csr;
  logic rs1_kul, rs2_kul, rd_kul, yasal, e_ihlal;
  logic [31:0] imm, rs1_deger, rs2_deger;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR) && (f3 == 3'b000);
    is_br    = (opcode == OP_BR) && (f3[2:1] == 2'b00);
    is_lw    = (opcode == OP_LOAD) && (f3 == 3'b010);
    is_sw    = (opcode == OP_STORE) && (f3 == 3'b010);
    is_addi  = (opcode == OP_IMM) && (f3 == 3'b000);
    is_r     = (opcode == OP_REG) &&
               (((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b100, 3'b110, 3'b111})) ||
                ((f7 == 7'b0100000) && (f3 == 3'b000)));
    is_csr   = 1'b0;
`ifdef ISLEMCI_SAYAC_EN
    is_csr   = (opcode == OP_SYS) && (f3 == 3'b010) && (rs1 == 5'd0) &&
               (buyruk_q[31:20] inside {12'hC00, 12'hC80, 12'hC02, 12'hC82});
`endif
    yasal    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_lw | is_sw | is_addi | is_r | is_csr;
    rs1_kul  = is_jalr | is_br | is_lw | is_sw | is_addi | is_r;
    rs2_kul  = is_br | is_sw | is_r;
    rd_kul   = is_lui | is_auipc | is_jal | is_jalr | is_lw | is_addi | is_r | is_csr;
    e_ihlal  = (YAZMAC_SAYISI == 16) &&
               ((rs1_kul && rs1[4]) || (rs2_kul && rs2[4]) || (rd_kul && rd[4]));

    imm = {{20{buyruk_q[31]}}, buyruk_q[31:20]};
    if (is_sw)                 imm = {{20{buyruk_q[31]}}, buyruk_q[31:25], buyruk_q[11:7]};
    else if (is_br)            imm = {{19{buyruk_q[31]}}, buyruk_q[31], buyruk_q[7],
                                      buyruk_q[30:25], buyruk_q[11:8], 1'b0};
    else if (is_lui | is_auipc) imm = {buyruk_q[31:12], 12'h000};
    else if (is_jal)           imm = {{11{buyruk_q[31]}}, buyruk_q[31], buyruk_q[19:12],
                                      buyruk_q[20], buyruk_q[30:21], 1'b0};

    rs1_deger = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1[IW-1:0]];
    rs2_deger = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2[IW-1:0]];
  end

`ifdef ISLEMCI_SAYAC_EN
  logic [63:0] cyc_q, cyc_d, ins_q, ins_d;
`endif
  logic [31:0] ps_arti4, ea, sonuc, sonraki_ps, sayac_deger;
  logic        atla;

  always_comb begin
    ps_arti4    = ps_q + 32'd4;
    ea          = a_q + imm_q;
    sayac_deger = 32'h0;
`ifdef ISLEMCI_SAYAC_EN
    case (buyruk_q[31:20])
      12'hC00: sayac_deger = cyc_q[31:0];
      12'hC80: sayac_deger = cyc_q[63:32];
      12'hC02: sayac_deger = ins_q[31:0];
      default: sayac_deger = ins_q[63:32];
    endcase
`endif
    sonuc = ea;
    if (is_lui)                 sonuc = imm_q;
    else if (is_auipc)          sonuc = ps_q + imm_q;
    else if (is_jal | is_jalr)  sonuc = ps_arti4;
    else if (is_csr)            sonuc = sayac_deger;
    else if (is_r) begin
      case (f3)
        3'b000:  sonuc = f7[5] ? (a_q - b_q) : (a_q + b_q);
        3'b100:  sonuc = a_q ^ b_q;
        3'b110:  sonuc = a_q | b_q;
        default: sonuc = a_q & b_q;
      endcase
    end
    atla       = f3[0] ? (a_q != b_q) : (a_q == b_q);
    sonraki_ps = ps_arti4;
    if (is_jal || (is_br && atla)) sonraki_ps = ps_q + imm_q;
    else if (is_jalr)              sonraki_ps = {ea[31:1], 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    buyruk_d = buyruk_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    addr_d   = addr_q;
    hata_d   = hata_q;
    rf_we    = 1'b0;
    rf_wd    = sonuc;
    case (state_q)
      SIFIR: state_d = GETIR;
      GETIR: if (bellek_hazir) begin
        buyruk_d = bellek_oku_veri;
        state_d  = COZ;
      end
      COZ: if (!yasal || e_ihlal) begin
        state_d = HATA;
        hata_d  = 1'b1;
      end else begin
        a_d     = rs1_deger;
        b_d     = rs2_deger;
        imm_d   = imm;
        state_d = YURUT;
      end
      YURUT: if (is_lw || is_sw) begin
        if (ea[1:0] != 2'b00) begin
          state_d = HATA;
          hata_d  = 1'b1;
        end else begin
          addr_d  = ea;
          state_d = BELLEK;
        end
      end else begin
        rf_we   = rd_kul;
        ps_d    = sonraki_ps;
        state_d = GETIR;
      end
      BELLEK: if (bellek_hazir) begin
        rf_we   = is_lw;
        rf_wd   = bellek_oku_veri;
        ps_d    = ps_arti4;
        state_d = GETIR;
      end
      default: state_d = HATA;
    endcase

    // Port outputs are registered from the next state so no memory input reaches them combinationally.
    istek_d    = (state_d == GETIR) || (state_d == BELLEK);
    yaz_d      = (state_d == BELLEK) && is_sw;
    adres_d    = (state_d == GETIR) ? ps_d : ((state_d == BELLEK) ? addr_d : 32'h0);
    yaz_veri_d = (state_d == BELLEK) ? b_q : 32'h0;
  end

  // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SIFIR;
      ps_q       <= BASLANGIC_ADRES;
      buyruk_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      addr_q     <= '0;
      hata_q     <= 1'b0;
      istek_q    <= 1'b0;
      yaz_q      <= 1'b0;
      adres_q    <= '0;
      yaz_veri_q <= '0;
      // NOTE: the register file must read as zero after reset, so it is built from resettable flops, not RAM.
      for (int i = 0; i < YAZMAC_SAYISI; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      buyruk_q   <= buyruk_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      addr_q     <= addr_d;
      hata_q     <= hata_d;
      istek_q    <= istek_d;
      yaz_q      <= yaz_d;
      adres_q    <= adres_d;
      yaz_veri_q <= yaz_veri_d;
      if (rf_we && (rd != 5'd0)) rf_q[rd[IW-1:0]] <= rf_wd;
    end
  end

`ifdef ISLEMCI_SAYAC_EN
  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if ((state_q != SIFIR) && (state_q != HATA)) cyc_d = cyc_q + 64'd1;
    if ((state_d == GETIR) && ((state_q == YURUT) || (state_q == BELLEK))) ins_d = ins_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end
`endif

  assign bellek_istek    = istek_q;
  assign bellek_yaz      = yaz_q;
  assign bellek_adres    = adres_q;
  assign bellek_yaz_veri = yaz_veri_q;
  assign hata            = hata_q;
endmodule
